checkpoint_ctrl: RTL and testbench

Allocation and sequencing controller for the `distributed_ram` checkpoint store. It owns the RAM's single address port and hands out slots in program order, writing snapshot data on allocate. It reads a snapshot back on a mispredict restore, discarding that slot and every younger one. It releases the oldest slot on commit, and sits between rename/branch logic and one `distributed_ram` instance.

---
 rtl/checkpoint_ctrl_if.sv | 34 +++
 rtl/checkpoint_ctrl.sv | 99 +++++++++
 tb/tb_checkpoint_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/checkpoint_ctrl_if.sv
// Client-side bundle of the checkpoint controller: allocation, commit-free and
// mispredict-restore channels plus the live-slot count.
interface checkpoint_ctrl_if #(
  parameter int WIDTH = 605,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             alloc_valid;
  logic [WIDTH-1:0] alloc_data;
  logic             alloc_ready;
  logic [AW-1:0]    alloc_id;
  logic             free_valid;
  logic             restore_valid;
  logic [AW-1:0]    restore_id;
  logic             restore_ready;
  logic             restore_done;
  logic [WIDTH-1:0] restore_data;
  logic             restore_err;
  logic [AW:0]      count;

  // The rename/branch side drives requests; the controller answers them.
  modport master (
    output alloc_valid, alloc_data, free_valid, restore_valid, restore_id,
    input  alloc_ready, alloc_id, restore_ready, restore_done, restore_data,
           restore_err, count
  );

  modport slave (
    input  alloc_valid, alloc_data, free_valid, restore_valid, restore_id,
    output alloc_ready, alloc_id, restore_ready, restore_done, restore_data,
           restore_err, count
  );
endinterface

// File: rtl/checkpoint_ctrl.sv
// Checkpoint slot allocator: hands out RAM slots in program order, restores a
// snapshot on mispredict (squashing younger slots) and frees the oldest on commit.
module checkpoint_ctrl #(
  parameter int WIDTH = 605,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  checkpoint_ctrl_if.slave         cp,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic                     ram_we,
  output logic [WIDTH-1:0]         ram_din,
  input  logic [WIDTH-1:0]         ram_dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] restore_data_q, restore_data_d;
  logic             restore_done_q, restore_done_d;
  logic             restore_err_q, restore_err_d;

  logic             rs_acc, rs_live, rs_ok, rs_bad;
  logic             free_acc, alloc_acc, alloc_ready;
  logic [AW-1:0]    head_post, rs_offset;
  logic [CW-1:0]    count_post;

  // Free is applied before the restore liveness check, so restoring the slot
  // being committed in the same cycle is rejected.
  always_comb begin
    rs_acc      = cp.restore_valid & (state_q == IDLE);
    free_acc    = cp.free_valid & (count_q != '0);
    head_post   = head_q + AW'(free_acc);
    count_post  = count_q - CW'(free_acc);
    rs_offset   = cp.restore_id - head_post;
    rs_live     = ({1'b0, rs_offset} < count_post);
    rs_ok       = rs_acc & rs_live;
    rs_bad      = rs_acc & ~rs_live;
    alloc_ready = (count_q != CW'(DEPTH)) & ~rs_acc;
    alloc_acc   = cp.alloc_valid & alloc_ready;

    ram_addr = tail_q;
    ram_we   = 1'b0;
    ram_din  = cp.alloc_data;
    if (rs_ok) begin
      ram_addr = cp.restore_id;
    end else if (alloc_acc) begin
      ram_we = 1'b1;
    end

    head_d         = head_post;
    tail_d         = tail_q + AW'(alloc_acc);
    count_d        = count_q + CW'(alloc_acc) - CW'(free_acc);
    restore_data_d = restore_data_q;
    restore_done_d = 1'b0;
    restore_err_d  = rs_bad;
    state_d        = IDLE;
    if (rs_ok) begin
      tail_d         = cp.restore_id;
      count_d        = {1'b0, rs_offset};
      restore_data_d = ram_dout;
      restore_done_d = 1'b1;
      state_d        = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      restore_data_q <= '0;
      restore_done_q <= 1'b0;
      restore_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      restore_data_q <= restore_data_d;
      restore_done_q <= restore_done_d;
      restore_err_q  <= restore_err_d;
    end
  end

  assign cp.alloc_ready   = alloc_ready;
  assign cp.alloc_id      = tail_q;
  assign cp.restore_ready = (state_q == IDLE);
  assign cp.restore_done  = restore_done_q;
  assign cp.restore_data  = restore_data_q;
  assign cp.restore_err   = restore_err_q;
  assign cp.count         = count_q;
endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Self-checking bench for checkpoint_ctrl: directed scenarios then random traffic,
// checked against a queue-of-live-slots reference model.
module tb_checkpoint_ctrl;
  localparam int W     = 605;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout;
  logic [W-1:0]  ram_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] id;
    logic [W-1:0]  data;
  } slot_t;

  slot_t        live_q[$];
  int           m_head;
  logic         m_resp;
  logic [W-1:0] m_data;

  checkpoint_ctrl_if #(.WIDTH(W), .DEPTH(DEPTH)) cp ();

  checkpoint_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cp       (cp),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Stand-in for distributed_ram: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
  end
  assign ram_dout = ram_mem[ram_addr];

  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs mid-cycle,
  // advance the model, then check registered outputs just after the edge.
  task automatic applyStimulus(input logic r, input logic av, input logic [W-1:0] ad,
                               input logic fv, input logic rv, input logic [AW-1:0] rid);
    logic e_rs_acc, e_aready, e_free, e_alloc, e_good, e_err;
    int   e_tail, k;
    @(negedge clk);
    rst = r; cp.alloc_valid = av; cp.alloc_data = ad; cp.free_valid = fv;
    cp.restore_valid = rv; cp.restore_id = rid;
    e_tail   = (m_head + live_q.size()) % DEPTH;
    e_rs_acc = rv && !m_resp;
    e_aready = (live_q.size() != DEPTH) && !e_rs_acc;
    e_free   = fv && (live_q.size() > 0);
    e_alloc  = av && e_aready;
    if (e_free) begin
      void'(live_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    k = -1;
    if (e_rs_acc) foreach (live_q[i]) if (live_q[i].id == rid) k = i;
    e_good = e_rs_acc && (k >= 0);
    e_err  = e_rs_acc && (k < 0);
    #1;
    checkOutput("alloc_ready", W'(cp.alloc_ready), W'(e_aready));
    checkOutput("alloc_id", W'(cp.alloc_id), W'(e_tail));
    checkOutput("restore_ready", W'(cp.restore_ready), W'(!m_resp));
    checkOutput("ram_we", W'(ram_we), W'(e_alloc));
    checkOutput("ram_addr", W'(ram_addr), e_good ? W'(rid) : W'(e_tail));
    if (e_alloc) checkOutput("ram_din", ram_din, ad);
    if (e_good) begin
      m_data = live_q[k].data;
      while (live_q.size() > k) void'(live_q.pop_back());
    end
    if (e_alloc) live_q.push_back('{id: AW'(e_tail), data: ad});
    m_resp = e_good;
    if (r) begin
      live_q.delete();
      m_head = 0; m_resp = 1'b0; m_data = '0; e_good = 1'b0; e_err = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("count", W'(cp.count), W'(live_q.size()));
    checkOutput("restore_done", W'(cp.restore_done), W'(e_good));
    checkOutput("restore_err", W'(cp.restore_err), W'(e_err));
    checkOutput("restore_data", cp.restore_data, m_data);
  endtask

  initial begin
    logic [W-1:0]  saved;
    logic [W-1:0]  slot0;
    logic [AW-1:0] tail_now;
    rst = 1'b1; cp.alloc_valid = 1'b0; cp.alloc_data = '0; cp.free_valid = 1'b0;
    cp.restore_valid = 1'b0; cp.restore_id = '0;
    live_q.delete(); m_head = 0; m_resp = 1'b0; m_data = '0;

    $display("[TB] reset");
    applyStimulus(1, 0, '0, 0, 0, '0);
    applyStimulus(1, 0, '0, 0, 0, '0);
    checkOutput("rst_count", W'(cp.count), W'(0));
    checkOutput("rst_alloc_ready", W'(cp.alloc_ready), W'(1));

    $display("[TB] fill and drain");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, W'(i), 0, 0, '0);
    checkOutput("fill_count", W'(cp.count), W'(16));
    checkOutput("fill_not_ready", W'(cp.alloc_ready), W'(0));
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, '0, 1, 0, '0);
    checkOutput("drain_count", W'(cp.count), W'(0));
    applyStimulus(0, 0, '0, 1, 0, '0);
    checkOutput("free_empty_count", W'(cp.count), W'(0));

    $display("[TB] restore mid-stack");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, W'(8'hA0 + i), 0, 0, '0);
    applyStimulus(0, 0, '0, 0, 1, AW'(3));
    checkOutput("mid_done", W'(cp.restore_done), W'(1));
    checkOutput("mid_data", cp.restore_data, W'(8'hA3));
    checkOutput("mid_count", W'(cp.count), W'(3));
    checkOutput("mid_next_id", W'(cp.alloc_id), W'(3));

    $display("[TB] wrap");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 0, '0);
    for (int i = 0; i < 11; i++) applyStimulus(0, 1, rand_payload(), 0, 0, '0);
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, '0, 1, 0, '0);
    slot0 = '0;
    for (int i = 0; i < 4; i++) begin
      saved = rand_payload();
      if (i == 2) slot0 = saved;
      applyStimulus(0, 1, saved, 0, 0, '0);
    end
    applyStimulus(0, 0, '0, 0, 1, AW'(0));
    checkOutput("wrap_data", cp.restore_data, slot0);
    checkOutput("wrap_count", W'(cp.count), W'(2));
    checkOutput("wrap_tail", W'(cp.alloc_id), W'(0));

    $display("[TB] conflicts");
    applyStimulus(0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, rand_payload(), 0, 0, '0);
    tail_now = cp.alloc_id;
    saved = ram_mem[tail_now];
    applyStimulus(0, 1, rand_payload(), 0, 1, AW'(15));
    checkOutput("rs_alloc_no_write", ram_mem[tail_now], saved);
    checkOutput("rs_alloc_count", W'(cp.count), W'(1));
    applyStimulus(0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, rand_payload(), 0, 0, '0);
    applyStimulus(0, 0, '0, 1, 1, AW'(14));
    checkOutput("head_free_err", W'(cp.restore_err), W'(1));
    checkOutput("head_free_count", W'(cp.count), W'(3));
    applyStimulus(0, 1, rand_payload(), 0, 0, '0);
    saved = cp.restore_data;
    applyStimulus(0, 0, '0, 0, 1, AW'(9));
    checkOutput("nonlive_err", W'(cp.restore_err), W'(1));
    checkOutput("nonlive_count", W'(cp.count), W'(4));
    checkOutput("nonlive_data", cp.restore_data, saved);
    checkOutput("nonlive_tail", W'(cp.alloc_id), W'(3));

    $display("[TB] full with alloc and free");
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, rand_payload(), 0, 0, '0);
    checkOutput("full_count", W'(cp.count), W'(16));
    applyStimulus(0, 1, rand_payload(), 1, 0, '0);
    checkOutput("full_af_count", W'(cp.count), W'(15));
    applyStimulus(0, 1, rand_payload(), 1, 0, '0);
    checkOutput("af_count", W'(cp.count), W'(15));
    checkOutput("af_tail", W'(cp.alloc_id), W'(0));

    $display("[TB] reset in RESP");
    applyStimulus(0, 0, '0, 0, 1, AW'(5));
    applyStimulus(1, 0, '0, 0, 0, '0);
    checkOutput("rr_done", W'(cp.restore_done), W'(0));
    checkOutput("rr_err", W'(cp.restore_err), W'(0));
    checkOutput("rr_data", cp.restore_data, W'(0));
    checkOutput("rr_count", W'(cp.count), W'(0));
    checkOutput("rr_alloc_id", W'(cp.alloc_id), W'(0));
    checkOutput("rr_alloc_ready", W'(cp.alloc_ready), W'(1));
    checkOutput("rr_restore_ready", W'(cp.restore_ready), W'(1));
    checkOutput("rr_ram_we", W'(ram_we), W'(0));
    checkOutput("rr_ram_addr", W'(ram_addr), W'(0));

    $display("[TB] random traffic");
    applyStimulus(1, 0, '0, 0, 0, '0);
    for (int n = 0; n < 400; n++) begin
      applyStimulus(0, ($urandom_range(0, 99) < 60), rand_payload(),
                    ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 12),
                    AW'($urandom_range(0, DEPTH - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
